// File: rtl/alt_trigout_reader_pkg.sv
// alt_trigout_reader_pkg
// Shared definitions for the alt-trigout FIFO reader:
//   - byte offsets of the trigout register bank
//   - bit positions inside the status, ctrl and seconds-high/mask registers
//   - controller state enum and the packed timestamp record
//   - ctrl_word(): packs {ext,ch4..ch1} enables into the ctrl register layout
package alt_trigout_reader_pkg;

  localparam logic [31:0] OFF_STATUS = 32'h00;
  localparam logic [31:0] OFF_CTRL   = 32'h04;
  localparam logic [31:0] OFF_SEC_HI = 32'h08;
  localparam logic [31:0] OFF_SEC_LO = 32'h0C;
  localparam logic [31:0] OFF_CYCLES = 32'h10;

  localparam int STAT_WR_EN_BIT      = 0;
  localparam int STAT_LINK_BIT       = 1;
  localparam int STAT_VALID_BIT      = 2;
  localparam int STAT_TS_PRESENT_BIT = 8;

  localparam int CTRL_CH_LSB  = 0;
  localparam int CTRL_EXT_BIT = 8;

  localparam int HI_SEC_LSB      = 0;
  localparam int HI_MASK_CH_LSB  = 16;
  localparam int HI_MASK_EXT_BIT = 24;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_CTRL,
    ST_RD_STAT,
    ST_RD_HI,
    ST_RD_LO,
    ST_RD_CYC,
    ST_EMIT
  } state_e;

  typedef struct packed {
    logic [39:0] sec;
    logic [27:0] cycles;
    logic [4:0]  mask;
  } ts_rec_t;

  function automatic logic [31:0] ctrl_word(input logic [4:0] en);
    ctrl_word = 32'h0;
    ctrl_word[CTRL_CH_LSB +: 4] = en[3:0];
    ctrl_word[CTRL_EXT_BIT]     = en[4];
  endfunction

endpackage

// File: rtl/alt_trigout_reader_wb_single_master.sv
// wb_single_master
// Single-outstanding-transaction pipelined Wishbone initiator.
//   start_i/we_i/adr_i/dat_i : launch request, accepted only while idle (busy_o=0)
//   busy_o                   : a transaction is in flight (cyc high)
//   done_o / err_o           : one-cycle completion flags (ack / err-or-timeout)
//   rdata_o                  : read data, valid in the done_o cycle
//   wb_*                     : Wishbone pipelined bus pins
// cyc and stb rise together; stb is held while stall is high and drops on
// the first non-stalled cycle; cyc is held until ack, err or timeout.
// The timeout counter is loaded when cyc rises, so cyc stays high for at
// most TIMEOUT cycles.
module wb_single_master #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        we_i,
  input  logic [31:0] adr_i,
  input  logic [31:0] dat_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [31:0] rdata_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_stall_i,
  input  logic        wb_err_i
);

  localparam int TW = $clog2(TIMEOUT + 1);

  logic          cyc_q, cyc_d;
  logic          stb_q, stb_d;
  logic          we_q, we_d;
  logic [31:0]   adr_q, adr_d;
  logic [31:0]   dat_q, dat_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          expired;

  always_comb begin
    cyc_d = cyc_q;
    stb_d = stb_q;
    we_d  = we_q;
    adr_d = adr_q;
    dat_d = dat_q;
    tmo_d = tmo_q;

    // An ack in the last allowed cycle still counts as success.
    expired = cyc_q && (tmo_q == '0) && !wb_ack_i;
    err_o   = cyc_q && (wb_err_i || expired);
    done_o  = cyc_q && wb_ack_i && !wb_err_i;

    if (!cyc_q) begin
      if (start_i) begin
        cyc_d = 1'b1;
        stb_d = 1'b1;
        we_d  = we_i;
        adr_d = adr_i;
        dat_d = dat_i;
        tmo_d = TW'(TIMEOUT - 1);
      end
    end else begin
      if (stb_q && !wb_stall_i) stb_d = 1'b0;
      if (tmo_q != '0) tmo_d = tmo_q - 1'b1;
      if (done_o || err_o) begin
        cyc_d = 1'b0;
        stb_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cyc_q <= 1'b0;
      stb_q <= 1'b0;
      we_q  <= 1'b0;
      adr_q <= 32'h0;
      dat_q <= 32'h0;
      tmo_q <= '0;
    end else begin
      cyc_q <= cyc_d;
      stb_q <= stb_d;
      we_q  <= we_d;
      adr_q <= adr_d;
      dat_q <= dat_d;
      tmo_q <= tmo_d;
    end
  end

  assign busy_o   = cyc_q;
  assign rdata_o  = wb_dat_i;
  assign wb_cyc_o = cyc_q;
  assign wb_stb_o = stb_q;
  assign wb_we_o  = we_q;
  assign wb_adr_o = adr_q;
  assign wb_dat_o = dat_q;

endmodule

// File: rtl/alt_trigout_reader.sv
// alt_trigout_reader
// Drains the alt-trigout timestamp FIFO through its Wishbone register bank
// and presents each record on a valid/ready stream.
//   clk_i, rst_i                 : clock, synchronous active-high reset
//   wb_*                         : pipelined Wishbone initiator pins
//   enable_i                     : run status polling
//   trig_en_i, trig_en_upd_i     : ctrl enables and their write request pulse
//   ts_valid_o/ts_ready_i, ts_*  : timestamp record stream
//   wr_status_o                  : last {valid,link,enable} read from status
//   bus_err_o                    : sticky bus error / timeout flag
// Optional: define ALT_TRIGOUT_READER_STATS_EN to add rec_cnt_o (records
// accepted on the stream) and lost_cnt_o (aborts of the popping cycles read).
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | wait for pending ctrl update or poll interval expiry
// ST_WR_CTRL | write trigger enables to ctrl
// ST_RD_STAT | read status, decide whether an entry is present
// ST_RD_HI   | read sec[39:32] and trigger mask
// ST_RD_LO   | read sec[31:0]
// ST_RD_CYC  | read cycles (pops the FIFO entry)
// ST_EMIT    | hold record on the stream until accepted
module alt_trigout_reader
  import alt_trigout_reader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR     = 32'h0,
  parameter int unsigned POLL_INTERVAL = 64,
  parameter int unsigned TIMEOUT       = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [3:0]  wb_sel_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_stall_i,
  input  logic        wb_err_i,
  input  logic        enable_i,
  input  logic [4:0]  trig_en_i,
  input  logic        trig_en_upd_i,
  output logic        ts_valid_o,
  input  logic        ts_ready_i,
  output logic [39:0] ts_sec_o,
  output logic [27:0] ts_cycles_o,
  output logic [4:0]  ts_mask_o,
  output logic [2:0]  wr_status_o,
  output logic        bus_err_o
`ifdef ALT_TRIGOUT_READER_STATS_EN
  ,
  output logic [15:0] rec_cnt_o,
  output logic [7:0]  lost_cnt_o
`endif
);

  localparam int            PW          = $clog2(POLL_INTERVAL + 1);
  localparam logic [PW-1:0] POLL_RELOAD = PW'(POLL_INTERVAL - 1);

  state_e        state_q, state_d;
  logic [PW-1:0] poll_q, poll_d;
  logic          pend_q, pend_d;
  logic [4:0]    pend_en_q, pend_en_d;
  ts_rec_t       rec_q, rec_d;
  logic          valid_q, valid_d;
  logic [2:0]    wrst_q, wrst_d;
  logic          berr_q, berr_d;

  logic          m_start, m_we, m_busy, m_done, m_err;
  logic [31:0]   m_adr, m_wdat, m_rdata;

  wb_single_master #(
    .TIMEOUT (TIMEOUT)
  ) u_master (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .start_i    (m_start),
    .we_i       (m_we),
    .adr_i      (m_adr),
    .dat_i      (m_wdat),
    .busy_o     (m_busy),
    .done_o     (m_done),
    .err_o      (m_err),
    .rdata_o    (m_rdata),
    .wb_cyc_o   (wb_cyc_o),
    .wb_stb_o   (wb_stb_o),
    .wb_we_o    (wb_we_o),
    .wb_adr_o   (wb_adr_o),
    .wb_dat_o   (wb_dat_o),
    .wb_dat_i   (wb_dat_i),
    .wb_ack_i   (wb_ack_i),
    .wb_stall_i (wb_stall_i),
    .wb_err_i   (wb_err_i)
  );

  always_comb begin
    state_d   = state_q;
    poll_d    = poll_q;
    pend_d    = pend_q;
    pend_en_d = pend_en_q;
    rec_d     = rec_q;
    valid_d   = valid_q;
    wrst_d    = wrst_q;
    berr_d    = berr_q;
    m_we      = 1'b0;
    m_adr     = BASE_ADDR + OFF_STATUS;
    m_wdat    = ctrl_word(pend_en_q);

    // Every bus state launches its transaction as soon as the engine is idle;
    // the engine goes idle in the same edge that moves us to the next state.
    m_start = (state_q inside {ST_WR_CTRL, ST_RD_STAT, ST_RD_HI, ST_RD_LO, ST_RD_CYC})
              && !m_busy;

    unique case (state_q)
      ST_IDLE: begin
        if (pend_q) state_d = ST_WR_CTRL;
        else if (enable_i && (poll_q == '0)) state_d = ST_RD_STAT;
      end
      ST_WR_CTRL: begin
        m_we  = 1'b1;
        m_adr = BASE_ADDR + OFF_CTRL;
        if (m_done) state_d = ST_IDLE;
      end
      ST_RD_STAT: begin
        m_adr = BASE_ADDR + OFF_STATUS;
        if (m_done) begin
          wrst_d = {m_rdata[STAT_VALID_BIT], m_rdata[STAT_LINK_BIT], m_rdata[STAT_WR_EN_BIT]};
          state_d = m_rdata[STAT_TS_PRESENT_BIT] ? ST_RD_HI : ST_IDLE;
        end
      end
      ST_RD_HI: begin
        m_adr = BASE_ADDR + OFF_SEC_HI;
        if (m_done) begin
          rec_d.sec[39:32] = m_rdata[HI_SEC_LSB +: 8];
          rec_d.mask       = {m_rdata[HI_MASK_EXT_BIT], m_rdata[HI_MASK_CH_LSB +: 4]};
          state_d          = ST_RD_LO;
        end
      end
      ST_RD_LO: begin
        m_adr = BASE_ADDR + OFF_SEC_LO;
        if (m_done) begin
          rec_d.sec[31:0] = m_rdata;
          state_d         = ST_RD_CYC;
        end
      end
      ST_RD_CYC: begin
        m_adr = BASE_ADDR + OFF_CYCLES;
        if (m_done) begin
          rec_d.cycles = m_rdata[27:0];
          valid_d      = 1'b1;
          state_d      = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (ts_ready_i) begin
          valid_d = 1'b0;
          // A queued ctrl update goes first; otherwise drain back-to-back.
          if (pend_q) state_d = ST_WR_CTRL;
          else if (enable_i) state_d = ST_RD_STAT;
          else state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (m_err) begin
      berr_d  = 1'b1;
      state_d = ST_IDLE;
    end

    // A pulse in the launch cycle re-arms the flag with the newer data.
    if (m_start && (state_q == ST_WR_CTRL)) pend_d = 1'b0;
    if (trig_en_upd_i) begin
      pend_d    = 1'b1;
      pend_en_d = trig_en_i;
    end

    if ((state_d == ST_IDLE) && (state_q != ST_IDLE)) poll_d = POLL_RELOAD;
    else if ((state_q == ST_IDLE) && (poll_q != '0)) poll_d = poll_q - 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      poll_q    <= POLL_RELOAD;
      pend_q    <= 1'b0;
      pend_en_q <= 5'h0;
      rec_q     <= '0;
      valid_q   <= 1'b0;
      wrst_q    <= 3'h0;
      berr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      poll_q    <= poll_d;
      pend_q    <= pend_d;
      pend_en_q <= pend_en_d;
      rec_q     <= rec_d;
      valid_q   <= valid_d;
      wrst_q    <= wrst_d;
      berr_q    <= berr_d;
    end
  end

  assign wb_sel_o    = 4'hF;
  assign ts_valid_o  = valid_q;
  assign ts_sec_o    = rec_q.sec;
  assign ts_cycles_o = rec_q.cycles;
  assign ts_mask_o   = rec_q.mask;
  assign wr_status_o = wrst_q;
  assign bus_err_o   = berr_q;

`ifdef ALT_TRIGOUT_READER_STATS_EN
  logic [15:0] rec_cnt_q;
  logic [7:0]  lost_cnt_q;

  // An abort of the cycles read may come after the slave already popped
  // the entry, so that record is counted as lost.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rec_cnt_q  <= 16'h0;
      lost_cnt_q <= 8'h0;
    end else begin
      if (valid_q && ts_ready_i && (rec_cnt_q != 16'hFFFF)) rec_cnt_q <= rec_cnt_q + 16'h1;
      if (m_err && (state_q == ST_RD_CYC) && (lost_cnt_q != 8'hFF)) lost_cnt_q <= lost_cnt_q + 8'h1;
    end
  end

  assign rec_cnt_o  = rec_cnt_q;
  assign lost_cnt_o = lost_cnt_q;
`endif

endmodule

// File: tb/tb_alt_trigout_reader.sv
module tb_alt_trigout_reader;

  localparam logic [31:0] BASE = 32'hFFFF_FFF0;  // offset 0x10 wraps to 0x0
  localparam int POLL = 64;
  localparam int TMO  = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [31:0] wb_adr_o, wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_i = 32'h0;
  logic        wb_ack_i = 1'b0, wb_stall_i = 1'b0, wb_err_i = 1'b0;
  logic        enable_i, trig_en_upd_i, ts_ready_i;
  logic [4:0]  trig_en_i;
  logic        ts_valid_o, bus_err_o;
  logic [39:0] ts_sec_o;
  logic [27:0] ts_cycles_o;
  logic [4:0]  ts_mask_o;
  logic [2:0]  wr_status_o;

  always #5 clk = ~clk;

  alt_trigout_reader #(
    .BASE_ADDR     (BASE),
    .POLL_INTERVAL (POLL),
    .TIMEOUT       (TMO)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .wb_cyc_o      (wb_cyc_o),
    .wb_stb_o      (wb_stb_o),
    .wb_we_o       (wb_we_o),
    .wb_adr_o      (wb_adr_o),
    .wb_sel_o      (wb_sel_o),
    .wb_dat_o      (wb_dat_o),
    .wb_dat_i      (wb_dat_i),
    .wb_ack_i      (wb_ack_i),
    .wb_stall_i    (wb_stall_i),
    .wb_err_i      (wb_err_i),
    .enable_i      (enable_i),
    .trig_en_i     (trig_en_i),
    .trig_en_upd_i (trig_en_upd_i),
    .ts_valid_o    (ts_valid_o),
    .ts_ready_i    (ts_ready_i),
    .ts_sec_o      (ts_sec_o),
    .ts_cycles_o   (ts_cycles_o),
    .ts_mask_o     (ts_mask_o),
    .wr_status_o   (wr_status_o),
    .bus_err_o     (bus_err_o)
  );

  typedef struct {
    logic [39:0] sec;
    logic [27:0] cyc;
    logic [4:0]  mask;
  } rec_t;

  rec_t fifo[$];   // slave FIFO contents
  rec_t exp_q[$];  // records the stream must deliver, in order

  int total = 0;
  int bad   = 0;

  // slave model state and bus observations
  logic [2:0]  stat_lo = 3'h0;
  int          stall_off = -1, stall_n = 0, noack_off = -1;
  bit          ack_pend = 0;
  logic [31:0] ack_dat = 32'h0;
  int          cycle_no = 0, stat_reads = 0, last_stat = 0, stat_period = 0;
  int          hi_reads = 0, txn_cnt = 0;
  int          last_off = -1;
  logic        last_we = 1'b0;
  logic [31:0] last_dat = 32'h0;
  int          cyc_len = 0;
  logic [31:0] cur_off = 32'h0;
  int          len_by_off[8];
  int          stall_stb_cnt = 0, emit_viol = 0;
  bit          valid_seen = 0;

  always @(negedge clk) begin : slave
    logic [31:0] off;
    cycle_no++;
    off = wb_adr_o - BASE;
    if (ts_valid_o) valid_seen = 1;
    if (ts_valid_o && wb_cyc_o) emit_viol++;
    if (wb_cyc_o && wb_stb_o && wb_stall_i) stall_stb_cnt++;
    if (wb_cyc_o) begin
      cyc_len++;
      cur_off = off;
    end else if (cyc_len != 0) begin
      len_by_off[cur_off[4:2]] = cyc_len;
      cyc_len = 0;
    end

    wb_ack_i = 1'b0;
    wb_dat_i = $urandom;
    if (ack_pend && wb_cyc_o) begin
      wb_ack_i = 1'b1;
      wb_dat_i = ack_dat;
    end
    ack_pend   = 0;
    wb_stall_i = 1'b0;

    if (wb_cyc_o && wb_stb_o) begin
      if (int'(off) == stall_off && stall_n > 0) begin
        wb_stall_i = 1'b1;
        stall_n--;
      end else begin
        txn_cnt++;
        last_off = int'(off);
        last_we  = wb_we_o;
        last_dat = wb_dat_o;
        ack_dat  = $urandom;  // undefined bits carry noise
        if (!wb_we_o) begin
          case (off)
            32'h00: begin
              ack_dat[8]   = (fifo.size() != 0);
              ack_dat[2:0] = stat_lo;
              stat_reads++;
              stat_period = cycle_no - last_stat;
              last_stat   = cycle_no;
            end
            32'h08: begin
              hi_reads++;
              if (fifo.size() != 0) begin
                ack_dat[7:0]   = fifo[0].sec[39:32];
                ack_dat[19:16] = fifo[0].mask[3:0];
                ack_dat[24]    = fifo[0].mask[4];
              end
            end
            32'h0C: if (fifo.size() != 0) ack_dat = fifo[0].sec[31:0];
            32'h10: if (fifo.size() != 0) begin
              ack_dat[27:0] = fifo[0].cyc;
              void'(fifo.pop_front());
            end
            default: ;
          endcase
        end
        if (int'(off) == noack_off) noack_off = -1;
        else ack_pend = 1;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic rec_t rand_rec();
    rec_t r;
    r.sec  = {8'($urandom), 32'($urandom)};
    r.cyc  = 28'($urandom);
    r.mask = 5'($urandom);
    return r;
  endfunction

  function automatic logic [31:0] ctrl_expect(input logic [4:0] en);
    return (en[4] ? 32'h100 : 32'h0) + 32'(en[3:0]);
  endfunction

  task automatic push_rec(input rec_t r);
    fifo.push_back(r);
    exp_q.push_back(r);
  endtask

  // Wait for a record, hold it 'hold' cycles, compare, hand it off.
  task automatic take_record(input string tag, input int hold, input bit restat);
    rec_t e;
    for (int i = 0; i < 400 && !ts_valid_o; i++) @(negedge clk);
    check({tag, "_valid"}, 64'(ts_valid_o), 64'h1);
    repeat (hold) @(negedge clk);
    check({tag, "_held"}, 64'(ts_valid_o), 64'h1);
    if (exp_q.size() == 0) begin
      check({tag, "_expected_any"}, 64'h0, 64'(exp_q.size() + 1));
      e = '{sec: 40'h0, cyc: 28'h0, mask: 5'h0};
    end else begin
      e = exp_q.pop_front();
    end
    check({tag, "_sec"}, 64'(ts_sec_o), 64'(e.sec));
    check({tag, "_cycles"}, 64'(ts_cycles_o), 64'(e.cyc));
    check({tag, "_mask"}, 64'(ts_mask_o), 64'(e.mask));
    ts_ready_i = 1'b1;
    @(negedge clk);
    ts_ready_i = 1'b0;
    check({tag, "_valid_drop"}, 64'(ts_valid_o), 64'h0);
    if (restat) begin
      @(negedge clk);
      check({tag, "_restat"}, 64'({wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o}),
            64'({1'b1, 1'b1, 1'b0, BASE}));
    end
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stim
    logic [4:0] en;
    int n;
    rec_t r;

    rst = 1'b1;
    enable_i = 1'b0;
    trig_en_i = 5'h0;
    trig_en_upd_i = 1'b0;
    ts_ready_i = 1'b0;
    stat_lo = 3'($urandom);
    repeat (3) @(negedge clk);

    check("rst_cyc", 64'(wb_cyc_o), 64'h0);
    check("rst_stb", 64'(wb_stb_o), 64'h0);
    check("rst_we_adr_dat", 64'({wb_we_o, wb_adr_o, wb_dat_o}), 64'h0);
    check("rst_sel", 64'(wb_sel_o), 64'hF);
    check("rst_valid", 64'(ts_valid_o), 64'h0);
    check("rst_err_status", 64'({bus_err_o, wr_status_o}), 64'h0);

    rst = 1'b0;
    enable_i = 1'b1;

    // empty FIFO: periodic status polls only
    for (int i = 0; i < 400 && stat_reads < 3; i++) @(negedge clk);
    check("poll_count", 64'(stat_reads >= 3), 64'h1);
    // poll interval plus launch, strobe and ack cycles of the status read
    check("poll_period", 64'(stat_period), 64'(POLL + 3));
    check("poll_no_hi", 64'(hi_reads), 64'h0);
    check("poll_no_valid", 64'(valid_seen), 64'h0);
    check("wr_status", 64'(wr_status_o), 64'(stat_lo));

    // ctrl update from IDLE with random enables
    repeat (5) @(negedge clk);
    en = 5'($urandom);
    n = txn_cnt;
    trig_en_i = en;
    trig_en_upd_i = 1'b1;
    @(negedge clk);
    trig_en_upd_i = 1'b0;
    for (int i = 0; i < 100 && txn_cnt == n; i++) @(negedge clk);
    check("ctrl_idle", 64'({last_we, 8'(last_off), last_dat}),
          64'({1'b1, 8'h04, ctrl_expect(en)}));

    // directed single record
    r = '{sec: 40'h12_3456_789A, cyc: 28'h0ABCDEF, mask: 5'b10011};
    push_rec(r);
    for (int i = 0; i < 400 && !ts_valid_o; i++) @(negedge clk);
    check("directed_popped", 64'(fifo.size()), 64'h0);
    take_record("directed", 0, 1);

    // three queued records, slow consumer
    emit_viol = 0;
    for (int k = 0; k < 3; k++) push_rec(rand_rec());
    take_record("burst0", 20, 1);
    take_record("burst1", $urandom_range(0, 5), 1);
    take_record("burst2", $urandom_range(0, 5), 1);
    check("emit_no_bus", 64'(emit_viol), 64'h0);

    // stall on the seconds-high read
    stall_stb_cnt = 0;
    stall_off = 8;
    stall_n = 4;
    push_rec(rand_rec());
    take_record("stall", 0, 1);
    check("stall_stb_cycles", 64'(stall_stb_cnt), 64'h4);
    check("stall_cyc_len", 64'(len_by_off[2]), 64'h6);
    stall_off = -1;

    // missing ack on the seconds-low read: timeout, then retry of same entry
    push_rec(rand_rec());
    noack_off = 12;
    for (int i = 0; i < 400 && !bus_err_o; i++) @(negedge clk);
    check("tmo_bus_err", 64'(bus_err_o), 64'h1);
    check("tmo_no_valid", 64'(ts_valid_o), 64'h0);
    @(negedge clk);
    check("tmo_cyc_len", 64'(len_by_off[3]), 64'(TMO));
    check("tmo_cyc_low", 64'(wb_cyc_o), 64'h0);
    take_record("after_tmo", 0, 1);
    check("tmo_sticky", 64'(bus_err_o), 64'h1);

    // ctrl update while a record is held on the stream
    push_rec(rand_rec());
    for (int i = 0; i < 400 && !ts_valid_o; i++) @(negedge clk);
    trig_en_i = 5'b10101;
    trig_en_upd_i = 1'b1;
    @(negedge clk);
    trig_en_upd_i = 1'b0;
    n = txn_cnt;
    take_record("emit_upd", 2, 0);
    for (int i = 0; i < 100 && txn_cnt == n; i++) @(negedge clk);
    check("ctrl_after_emit", 64'({last_we, 8'(last_off), last_dat}),
          64'({1'b1, 8'h04, 32'h0000_0105}));

    // polling stops when disabled
    enable_i = 1'b0;
    repeat (10) @(negedge clk);
    n = stat_reads;
    repeat (200) @(negedge clk);
    check("disabled_no_poll", 64'(stat_reads), 64'(n));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
